moore11011_l: RTL and testbench



---
 rtl/moore11011_l_pkg.sv | 17 +
 rtl/moore11011_l.sv | 42 ++++
 tb/tb_moore11011_l.sv | 135 +++++++++++++
 3 files changed

// File: rtl/moore11011_l_pkg.sv
// Shared types and constants for the overlapping 11011 Moore sequence detector.
package moore11011_l_pkg;

  // Each state is named after the longest prefix of 11011 seen so far.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_e;

  localparam logic [4:0]  PATTERN     = 5'b11011;
  localparam int unsigned PATTERN_LEN = 5;

endpackage

// File: rtl/moore11011_l.sv
// Overlapping Moore detector for the serial pattern 11011 (first bit first).
// out is a registered decode of the next state, so it is glitch-free and tracks state==S5.
module moore11011_l
  import moore11011_l_pkg::*;
(
  output logic out,
  input  logic in,
  input  logic clk,
  input  logic rst
);

  state_e r_state;
  state_e w_next;
  logic   r_out;

  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = in ? S1 : S0;
      S1:      w_next = in ? S2 : S0;
      S2:      w_next = in ? S2 : S3;
      S3:      w_next = in ? S4 : S0;
      S4:      w_next = in ? S5 : S0;
      // A completed match leaves "11" or "110" as a reusable suffix.
      S5:      w_next = in ? S2 : S3;
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == S5);
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_moore11011_l.sv
// Scoreboard bench for moore11011_l: stimulus pushes the expected out per sampled bit,
// a monitor pops and compares 1ns after every rising edge.
`timescale 1ns/1ps
module tb_moore11011_l;
  import moore11011_l_pkg::*;

  logic out;
  logic in;
  logic clk;
  logic rst;

  int   checks = 0;
  int   errors = 0;
  logic sb_q[$];
  logic prev_out = 1'b0;

  moore11011_l dut (
    .out (out),
    .in  (in),
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected value per sampled bit; also flags back-to-back pulses.
  always @(posedge clk) begin
    logic e;
    #1;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("out", {7'd0, out}, {7'd0, e});
    end
    if (!rst && prev_out) check("no_consecutive", {7'd0, out}, 8'd0);
    prev_out = rst ? 1'b0 : out;
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_bit(input logic b, input logic e);
    in = b;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive_str(input string bits, input string exps);
    for (int i = 0; i < bits.len(); i++)
      drive_bit(bits.getc(i) == "1", exps.getc(i) == "1");
  endtask

  // Holds reset across two edges, checking it, and releases at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    in  = 1'bx;
    #1;
    check("rst_async_out", {7'd0, out}, 8'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_out", {7'd0, out}, 8'd0);
      check("rst_state", {5'd0, dut.r_state}, {5'd0, S0});
    end
    rst = 1'b0;
  endtask

  string seq_bits[5] = '{"110110111011", "11011011", "1101011011", "1111011", "110111011"};
  string seq_exps[5] = '{"000010010001", "00001001", "0000000001", "0000001", "000010001"};

  initial begin
    logic [4:0] sr;
    int         cnt;
    logic       b;

    rst = 1'b1;
    in  = 1'bx;
    #1;
    check("init_out", {7'd0, out}, 8'd0);
    check("init_state", {5'd0, dut.r_state}, {5'd0, S0});
    #6;
    check("init_out_after_edge", {7'd0, out}, 8'd0);
    @(negedge clk);
    do_reset();

    for (int s = 0; s < 5; s++) begin
      drive_str(seq_bits[s], seq_exps[s]);
      do_reset();
    end

    // Partial match discarded by reset; full 5 bits needed afterwards.
    drive_str("1101", "0000");
    do_reset();
    drive_str("1", "0");
    drive_str("1011", "0001");

    // Asynchronous reset while the pulse is high, half way through the cycle.
    do_reset();
    drive_str("11011", "00001");
    check("pulse_before_async", {7'd0, out}, 8'd1);
    rst = 1'b1;
    #1;
    check("async_clear_out", {7'd0, out}, 8'd0);
    check("async_clear_state", {5'd0, dut.r_state}, {5'd0, S0});
    do_reset();

    // Random stream against a shift-register reference.
    sr  = 5'd0;
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      b   = 1'($urandom_range(0, 1));
      sr  = {sr[3:0], b};
      cnt = cnt + 1;
      drive_bit(b, (cnt >= PATTERN_LEN) && (sr == PATTERN));
    end

    check("queue_drained", 8'(sb_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
